// File: rtl/gray_step_decoder.sv
// Two-stage Gray-to-binary decoder that classifies each decoded sample as step up, step down or skip.
// Latency 2 cycles from g_valid to bin_valid; one sample per cycle, never stalls.
module gray_step_decoder #(
   parameter int WIDTH = 4,
   parameter int POSW  = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             g_valid,
   input  logic [WIDTH-1:0] g_in,
   output logic             bin_valid,
   output logic [WIDTH-1:0] bin_out,
   output logic             step_up,
   output logic             step_down,
   output logic             skip_err,
   output logic [POSW-1:0]  pos,
   output logic [7:0]       err_cnt
);

   typedef enum logic {EMPTY, TRACK} state_t;

   localparam logic [WIDTH-1:0] D_UP    = WIDTH'(1);
   localparam logic [WIDTH-1:0] D_DOWN  = '1;
   localparam logic [POSW-1:0]  POS_MAX = {1'b0, {(POSW-1){1'b1}}};
   localparam logic [POSW-1:0]  POS_MIN = {1'b1, {(POSW-1){1'b0}}};

   state_t           state_q;
   logic [WIDTH-1:0] g_q;
   logic             v1_q;
   logic [WIDTH-1:0] bin_q;
   logic [WIDTH-1:0] bin_d;
   logic [WIDTH-1:0] diff_d;
   logic             bin_valid_q;
   logic             step_up_q;
   logic             step_down_q;
   logic             skip_err_q;
   logic [POSW-1:0]  pos_q;
   logic [7:0]       err_q;

   // bin_q doubles as the previous sample: it only changes on a decode.
   always_comb begin
      bin_d = '0;
      for (int i = 0; i < WIDTH; i++) begin
         bin_d[i] = ^(g_q >> i);
      end
      diff_d = bin_d - bin_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         g_q         <= '0;
         v1_q        <= 1'b0;
         bin_q       <= '0;
         bin_valid_q <= 1'b0;
         step_up_q   <= 1'b0;
         step_down_q <= 1'b0;
         skip_err_q  <= 1'b0;
         pos_q       <= '0;
         err_q       <= '0;
         state_q     <= EMPTY;
      end else if (clear) begin
         v1_q        <= 1'b0;
         bin_valid_q <= 1'b0;
         step_up_q   <= 1'b0;
         step_down_q <= 1'b0;
         skip_err_q  <= 1'b0;
         pos_q       <= '0;
         err_q       <= '0;
         state_q     <= EMPTY;
      end else begin
         v1_q <= g_valid;
         if (g_valid) begin
            g_q <= g_in;
         end
         bin_valid_q <= v1_q;
         step_up_q   <= 1'b0;
         step_down_q <= 1'b0;
         skip_err_q  <= 1'b0;
         if (v1_q) begin
            bin_q <= bin_d;
            case (state_q)
               EMPTY: begin
                  state_q <= TRACK;
               end
               TRACK: begin
                  if (diff_d == D_UP) begin
                     step_up_q <= 1'b1;
                     if (pos_q != POS_MAX) pos_q <= pos_q + POSW'(1);
                  end else if (diff_d == D_DOWN) begin
                     step_down_q <= 1'b1;
                     if (pos_q != POS_MIN) pos_q <= pos_q - POSW'(1);
                  end else if (diff_d != '0) begin
                     skip_err_q <= 1'b1;
                     if (err_q != 8'hFF) err_q <= err_q + 8'd1;
                  end
               end
               default: state_q <= EMPTY;
            endcase
         end
      end
   end

   assign bin_valid = bin_valid_q;
   assign bin_out   = bin_q;
   assign step_up   = step_up_q;
   assign step_down = step_down_q;
   assign skip_err  = skip_err_q;
   assign pos       = pos_q;
   assign err_cnt   = err_q;

endmodule

// File: tb/tb_gray_step_decoder.sv
// Directed bench for gray_step_decoder: a POSW=16 instance and a POSW=4 instance share one stimulus stream.
module tb_gray_step_decoder;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       clear;
   logic       g_valid;
   logic [3:0] g_in;

   logic        bv, up, dn, sk;
   logic [3:0]  b;
   logic [15:0] p;
   logic [7:0]  e;

   logic        s_bv, s_up, s_dn, s_sk;
   logic [3:0]  s_b;
   logic [3:0]  s_p;
   logic [7:0]  s_e;

   int checks   = 0;
   int failures = 0;

   gray_step_decoder #(.WIDTH(4), .POSW(16)) u_dut (
      .clk(clk), .rst_n(rst_n), .clear(clear), .g_valid(g_valid), .g_in(g_in),
      .bin_valid(bv), .bin_out(b), .step_up(up), .step_down(dn), .skip_err(sk),
      .pos(p), .err_cnt(e)
   );

   gray_step_decoder #(.WIDTH(4), .POSW(4)) u_sat (
      .clk(clk), .rst_n(rst_n), .clear(clear), .g_valid(g_valid), .g_in(g_in),
      .bin_valid(s_bv), .bin_out(s_b), .step_up(s_up), .step_down(s_dn), .skip_err(s_sk),
      .pos(s_p), .err_cnt(s_e)
   );

   always #5 clk = ~clk;

   function automatic logic [3:0] gray(input int v);
      logic [3:0] x;
      x = 4'(v);
      return x ^ (x >> 1);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Expected outputs after the most recent edge; ps is the POSW=4 position.
   task automatic exp_out(input string tag, input int xbv, input int xb, input int xup,
                          input int xdn, input int xsk, input int xp, input int xps, input int xe);
      chk({tag, ".bin_valid"}, 32'(bv), 32'(xbv));
      chk({tag, ".bin_out"},   32'(b),  32'(xb));
      chk({tag, ".step_up"},   32'(up), 32'(xup));
      chk({tag, ".step_down"}, 32'(dn), 32'(xdn));
      chk({tag, ".skip_err"},  32'(sk), 32'(xsk));
      chk({tag, ".pos"},       32'(p),  32'(xp));
      chk({tag, ".err_cnt"},   32'(e),  32'(xe));
      chk({tag, ".sat_valid"}, 32'(s_bv), 32'(xbv));
      chk({tag, ".sat_bin"},   32'(s_b),  32'(xb));
      chk({tag, ".sat_up"},    32'(s_up), 32'(xup));
      chk({tag, ".sat_down"},  32'(s_dn), 32'(xdn));
      chk({tag, ".sat_skip"},  32'(s_sk), 32'(xsk));
      chk({tag, ".sat_pos"},   32'(s_p),  32'(xps));
      chk({tag, ".sat_err"},   32'(s_e),  32'(xe));
   endtask

   task automatic cyc(input logic v, input logic [3:0] g, input logic clr);
      g_valid = v;
      g_in    = g;
      clear   = clr;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; clear = 1'b0; g_valid = 1'b0; g_in = 4'h0;
      cyc(1'b1, 4'hF, 1'b0);
      cyc(1'b0, 4'h0, 1'b0);
      exp_out("reset", 0, 0, 0, 0, 0, 0, 0, 0);

      // Sweep 0..15; the POSW=4 instance saturates at +7 while step_up keeps pulsing.
      rst_n = 1'b1;
      for (int i = 0; i < 16; i++) begin
         cyc(1'b1, gray(i), 1'b0);
         if (i > 0)
            exp_out($sformatf("sweep%0d", i - 1), 1, i - 1, (i > 1) ? 1 : 0, 0, 0,
                    i - 1, (i - 1 > 7) ? 7 : i - 1, 0);
      end
      cyc(1'b0, 4'h0, 1'b0);
      exp_out("sweep15", 1, 15, 1, 0, 0, 15, 7, 0);
      cyc(1'b0, 4'h0, 1'b0);
      exp_out("sweep_gap", 0, 15, 0, 0, 0, 15, 7, 0);

      // Wrap up 15->0, then wrap down 0->15.
      cyc(1'b1, 4'b0000, 1'b0);
      exp_out("wrap_idle", 0, 15, 0, 0, 0, 15, 7, 0);
      cyc(1'b1, 4'b1000, 1'b0);
      exp_out("wrap_up", 1, 0, 1, 0, 0, 16, 7, 0);
      cyc(1'b0, 4'h0, 1'b0);
      exp_out("wrap_down", 1, 15, 0, 1, 0, 15, 6, 0);

      // Clear with one sample in stage 1 and another presented on the clear cycle.
      cyc(1'b1, gray(5), 1'b0);
      exp_out("clr_pre", 0, 15, 0, 0, 0, 15, 6, 0);
      cyc(1'b1, gray(9), 1'b1);
      exp_out("clr_edge", 0, 15, 0, 0, 0, 0, 0, 0);
      cyc(1'b0, 4'h0, 1'b0);
      exp_out("clr_flush", 0, 15, 0, 0, 0, 0, 0, 0);

      // First sample after clear (3) has no flag; 3->6 skips; 6->7 steps up.
      cyc(1'b1, 4'b0010, 1'b0);
      exp_out("skip_idle", 0, 15, 0, 0, 0, 0, 0, 0);
      cyc(1'b1, 4'b0101, 1'b0);
      exp_out("skip_first", 1, 3, 0, 0, 0, 0, 0, 0);
      cyc(1'b1, 4'b0100, 1'b0);
      exp_out("skip_6", 1, 6, 0, 0, 1, 0, 0, 1);
      cyc(1'b0, 4'h0, 1'b0);
      exp_out("skip_7", 1, 7, 1, 0, 0, 1, 1, 1);

      // Repeats of 7 separated by idle cycles.
      cyc(1'b1, 4'b0100, 1'b0);
      exp_out("rep_gap0", 0, 7, 0, 0, 0, 1, 1, 1);
      cyc(1'b0, 4'h0, 1'b0);
      exp_out("rep_a", 1, 7, 0, 0, 0, 1, 1, 1);
      cyc(1'b0, 4'h0, 1'b0);
      exp_out("rep_gap1", 0, 7, 0, 0, 0, 1, 1, 1);
      cyc(1'b0, 4'h0, 1'b0);
      exp_out("rep_gap2", 0, 7, 0, 0, 0, 1, 1, 1);
      cyc(1'b1, 4'b0100, 1'b0);
      exp_out("rep_gap3", 0, 7, 0, 0, 0, 1, 1, 1);
      cyc(1'b0, 4'h0, 1'b0);
      exp_out("rep_b", 1, 7, 0, 0, 0, 1, 1, 1);

      // 260 forced skips alternating 0 and 8; err_cnt starts at 1 and saturates at 255.
      for (int k = 0; k < 260; k++) begin
         cyc(1'b1, (k % 2 == 0) ? 4'b0000 : 4'b1100, 1'b0);
         if (k > 0)
            exp_out($sformatf("errsat%0d", k - 1), 1, ((k - 1) % 2 == 0) ? 0 : 8, 0, 0, 1,
                    1, 1, (k + 1 > 255) ? 255 : k + 1);
      end
      cyc(1'b0, 4'h0, 1'b0);
      exp_out("errsat_last", 1, 8, 0, 0, 1, 1, 1, 255);
      cyc(1'b0, 4'h0, 1'b0);
      exp_out("errsat_idle", 0, 8, 0, 0, 0, 1, 1, 255);

      // Reset with a sample in flight clears bin_out too; next sample carries no flag.
      cyc(1'b1, gray(2), 1'b0);
      exp_out("rst_pre", 0, 8, 0, 0, 0, 1, 1, 255);
      rst_n = 1'b0;
      cyc(1'b0, 4'h0, 1'b0);
      exp_out("rst_mid", 0, 0, 0, 0, 0, 0, 0, 0);
      rst_n = 1'b1;
      cyc(1'b1, gray(1), 1'b0);
      exp_out("rst_flush", 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(1'b0, 4'h0, 1'b0);
      exp_out("rst_first", 1, 1, 0, 0, 0, 0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/gray_step_decoder.md
# gray_step_decoder

Registered Gray-to-binary decoder with step tracking. Accepts Gray-coded position samples, converts them to binary through a two-stage pipeline, and classifies each change as a step up, a step down, or an illegal skip. It keeps a saturating signed position count and an error count. It sits downstream of Gray-coded position sources, such as encoder wheels and Gray pointers, and is the receiving end of the binary-to-Gray conversion path.

## Interface
- WIDTH, 4, Gray/binary code width; legal range 2–16
- POSW, 16, width of the signed position accumulator
- clk  in  1  rising-edge clock
- rst_n  in  1  reset: synchronous, active-low; sampled on the rising edge of clk
- clear  in  1  synchronous soft clear of the tracker (see Operation)
- g_valid  in  1  g_in is a valid sample this cycle
- g_in  in  WIDTH  Gray-coded sample
- bin_valid  out  1  bin_out and the step flags are valid this cycle (1-cycle pulse)
- bin_out  out  WIDTH  decoded binary value
- step_up  out  1  pulse: sample is previous value +1 mod 2^WIDTH
- step_down  out  1  pulse: sample is previous value −1 mod 2^WIDTH
- skip_err  out  1  pulse: sample differs from previous by more than ±1
- pos  out  POSW  signed accumulated position
- err_cnt  out  8  count of skip errors; saturates at 255

## Operation
- Stage 1: when g_valid=1, register g_in into g_q and set v1=1; otherwise v1=0.
- Stage 2: when v1=1, decode b[WIDTH−1]=g_q[WIDTH−1] and b[i]=b[i+1]^g_q[i]. Register the result into bin_out and assert bin_valid.
- FSM states:
  - EMPTY: no reference value held. Entered from reset or clear.
  - TRACK: prev holds the last decoded value.
- EMPTY behaviour on a decoded sample:
  - bin_valid=1 with all step flags 0.
  - prev ← sample; pos and err_cnt unchanged; go to TRACK.
- TRACK behaviour on a decoded sample, with d = (sample − prev) mod 2^WIDTH:
  - d=0: bin_valid=1, no flag; pos unchanged.
  - d=1: step_up=1; pos+1.
  - d=2^WIDTH−1: step_down=1; pos−1.
  - Any other d: skip_err=1; err_cnt+1, saturating at 255; pos unchanged.
  - prev ← sample in every case. This resyncs after a skip.
- Wrap-around: all-ones→0 is a step up, and 0→all-ones is a step down.
- pos arithmetic: saturates at +(2^(POSW−1)−1) and −2^(POSW−1). At a limit the step flag still pulses and pos holds.
- At most one of step_up, step_down and skip_err is high in any cycle, and only when bin_valid=1.
- clear=1:
  - Flush v1 and bin_valid.
  - pos←0, err_cnt←0, go to EMPTY.
  - A g_valid in the same cycle is discarded.
  - bin_out holds its last value.
  - clear takes priority over every other event.
- rst_n=0: same effect as clear, and additionally bin_out←0 and g_q←0. rst_n takes priority over clear.

## Timing
- Latency: g_valid at edge N produces bin_valid at edge N+2. Throughput is one sample per cycle, back-to-back, with no stall or backpressure.
- The step flags, pos and err_cnt update on the same edge as bin_valid.
- Reset values: bin_valid=0, bin_out=0, step_up=0, step_down=0, skip_err=0, pos=0, err_cnt=0, FSM=EMPTY.
- A sample in flight when reset or clear asserts never produces a bin_valid.
- The first sample after reset or clear never raises a flag.

## Test plan
- Reset then full sweep (WIDTH=4):
  - Stimulus: release rst_n, then drive Gray codes for binary 0..15 back-to-back.
  - Response: bin_out is 0..15 two cycles after each sample.
  - Flags: first sample has no flag; then 15 step_up pulses.
  - Final state: pos=15, err_cnt=0.
- Wrap-up and wrap-down:
  - Stimulus: Gray 1000 (bin 15) → 0000 → 1000.
  - Response: step_up then step_down; pos returns to its starting value.
- Skip detection:
  - Stimulus: bin 3 (0010) → bin 6 (0101) → bin 7 (0100).
  - Response: skip_err on the 6 sample with pos unchanged and err_cnt=1; then step_up on 7.
- Repeat and gaps:
  - Stimulus: the same code twice, with g_valid idle cycles between samples.
  - Response: bin_valid with no flags; bin_valid low during gaps; no pos change.
- Clear mid-stream:
  - Stimulus: assert clear while two samples are in the pipeline.
  - Response: no bin_valid for those samples; pos=0, err_cnt=0; the next sample gives bin_valid with no flag.
- Saturation:
  - Config: POSW=4.
  - Stimulus: 10 up steps.
  - Response: pos stops at 7 while step_up keeps pulsing.
  - Error count: 260 forced skips leave err_cnt=255.
